// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: states, opcodes,
// ALU operation classes, ALU control codes and immediate-format selects.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_LUI      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_U = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format implied by the opcode; unknown opcodes fall back to I.
   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_STORE: imm_sel = IMM_S;
         OP_LUI:   imm_sel = IMM_U;
         OP_JAL:   imm_sel = IMM_J;
         default:  imm_sel = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from operation class and instruction fields.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      if (aluop == ALUOP_FUNCT) begin
         case (funct3)
            // Subtract only for R-type; addi never subtracts regardless of bit 30.
            3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alucontrol = ALU_SLT;
            3'b110:  alucontrol = ALU_OR;
            3'b111:  alucontrol = ALU_AND;
            default: alucontrol = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath with optional memory
// wait states; write enables are suppressed while reset is high.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_EN = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       adrsrc,
   output logic       illegal,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] immsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state_dbg
);

   state_t state, state_nxt;
   aluop_t aluop;
   logic   mem_rdy;
   logic   pcw, irw, memw, regw, ill;

   assign mem_rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      aluop     = ALUOP_ADD;
      pcw       = 1'b0;
      irw       = 1'b0;
      memw      = 1'b0;
      regw      = 1'b0;
      ill       = 1'b0;
      adrsrc    = 1'b0;
      resultsrc = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      immsrc    = 2'b00;
      case (state)
         S_FETCH: begin
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            if (mem_rdy) begin
               irw       = 1'b1;
               pcw       = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            immsrc  = imm_sel(op);
            case (op)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_RTYPE:          state_nxt = S_EXECUTER;
               OP_ITYPE:          state_nxt = S_EXECUTEI;
               OP_JAL:            state_nxt = S_JAL;
               OP_LUI:            state_nxt = S_LUI;
               default: begin
                  ill       = 1'b1;
                  state_nxt = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca   = 2'b10;
            alusrcb   = 2'b01;
            immsrc    = imm_sel(op);
            state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adrsrc = 1'b1;
            if (mem_rdy) state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc = 2'b01;
            regw      = 1'b1;
            state_nxt = S_FETCH;
         end
         S_MEMWRITE: begin
            adrsrc = 1'b1;
            memw   = 1'b1;
            if (mem_rdy) state_nxt = S_FETCH;
         end
         S_EXECUTER: begin
            alusrca   = 2'b10;
            aluop     = ALUOP_FUNCT;
            state_nxt = S_ALUWB;
         end
         S_EXECUTEI: begin
            alusrca   = 2'b10;
            alusrcb   = 2'b01;
            immsrc    = imm_sel(op);
            aluop     = ALUOP_FUNCT;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            regw      = 1'b1;
            state_nxt = S_FETCH;
         end
         S_JAL: begin
            alusrca   = 2'b01;
            alusrcb   = 2'b10;
            immsrc    = imm_sel(op);
            pcw       = 1'b1;
            state_nxt = S_ALUWB;
         end
         S_LUI: begin
            alusrca   = 2'b11;
            alusrcb   = 2'b01;
            immsrc    = imm_sel(op);
            state_nxt = S_ALUWB;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   // Gate side-effecting strobes so a mid-stall reset cannot commit anything.
   assign pcwrite   = pcw  & ~reset;
   assign irwrite   = irw  & ~reset;
   assign memwrite  = memw & ~reset;
   assign regwrite  = regw & ~reset;
   assign illegal   = ill  & ~reset;
   assign state_dbg = state;

   alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .op5        (op[5]),
      .alucontrol (alucontrol)
   );

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1; 1 = honour mem_ready, 0 = treat mem_ready as constant 1.
REQ-002 SHALL have ports clk, in, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have ports reset, in, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports op, in, 7, opcode; funct3, in, 3; funct7b5, in, 1; mem_ready, in, 1, memory access completes this cycle.
REQ-005 SHALL have ports pcwrite, irwrite, memwrite, regwrite, adrsrc, illegal, out, 1 each.
REQ-006 SHALL have ports resultsrc, alusrca, alusrcb, immsrc, out, 2 each; alucontrol, out, 3; state_dbg, out, 4.

Function
REQ-007 SHALL be a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, LUI=10; state_dbg = current state.
REQ-008 SHALL drive every output 0 unless listed for the current state.
REQ-009 SHALL in FETCH drive alusrcb=10, resultsrc=10, aluop=add; assert irwrite and pcwrite only when mem_ready=1; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-010 SHALL in DECODE drive alusrca=01, alusrcb=01, aluop=add, immsrc from opcode; go to MEMADR for 0000011/0100011, EXECUTER for 0110011, EXECUTEI for 0010011, JAL for 1101111, LUI for 0110111.
REQ-011 SHALL, for any other opcode in DECODE, including branches, pulse illegal=1 for one cycle and return to FETCH with no write enable asserted.
REQ-012 SHALL map immsrc as I=00 (lw, I-ALU), S=01 (sw), U=10 (lui), J=11 (jal); immsrc SHALL be held in DECODE, MEMADR, EXECUTEI, JAL and LUI.
REQ-013 SHALL in MEMADR drive alusrca=10, alusrcb=01, aluop=add; go to MEMREAD for load, MEMWRITE for store.
REQ-014 SHALL in MEMREAD drive adrsrc=1, resultsrc=00; hold until mem_ready=1, then go to MEMWB.
REQ-015 SHALL in MEMWB drive resultsrc=01, regwrite=1, then go to FETCH.
REQ-016 SHALL in MEMWRITE drive adrsrc=1, resultsrc=00, memwrite=1; hold with memwrite high until mem_ready=1, then go to FETCH.
REQ-017 SHALL in EXECUTER drive alusrca=10, alusrcb=00, aluop=funct; in EXECUTEI drive alusrca=10, alusrcb=01, aluop=funct; both go to ALUWB.
REQ-018 SHALL in ALUWB drive resultsrc=00, regwrite=1, then go to FETCH.
REQ-019 SHALL in JAL drive alusrca=01, alusrcb=10, aluop=add, resultsrc=00, pcwrite=1, then go to ALUWB.
REQ-020 SHALL in LUI drive alusrca=11 (zero), alusrcb=01, aluop=add, then go to ALUWB.
REQ-021 SHALL decode alucontrol: aluop add -> 000; aluop funct with funct3=000 -> 001 (sub) if op[5]&funct7b5, else 000; 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); other funct3 -> 000.
REQ-022 SHALL keep latency at 4 cycles for R/I/jal/lui, 5 for lw, and 4 for sw, plus wait cycles.

Reset
REQ-023 SHALL load state FETCH on the clock edge where reset=1.
REQ-024 SHALL force pcwrite, irwrite, memwrite, regwrite and illegal to 0 combinationally while reset=1, including reset in the middle of a stall.

Structure
REQ-025 SHALL take state encodings, opcode constants, aluop, alucontrol and immsrc codes from shared package riscv_ctrl_pkg.
REQ-026 SHALL put ALU decoding in combinational sub-module alu_decoder, with inputs aluop, funct3, funct7b5, op5 and output alucontrol.

Verification
REQ-027 SHALL check: reset high 2 cycles, mem_ready=1 -> all write enables 0 during reset; cycle after release FETCH with pcwrite=irwrite=1.
REQ-028 SHALL check: op=0110011, funct3=000, funct7b5=1 -> FETCH, DECODE, EXECUTER (alucontrol=001), ALUWB (regwrite=1) -> FETCH in 4 cycles.
REQ-029 SHALL check: lw (0000011) with mem_ready=0 for 3 cycles in MEMREAD -> adrsrc=1 held 4 cycles; MEMWB resultsrc=01, regwrite=1; 8 cycles total.
REQ-030 SHALL check: sw (0100011) -> immsrc=01 in MEMADR; memwrite=1 until mem_ready; regwrite never asserted.
REQ-031 SHALL check: jal (1101111) -> immsrc=11 in DECODE; JAL pcwrite=1 with alusrcb=10; ALUWB regwrite=1; lui -> alusrca=11, immsrc=10.
REQ-032 SHALL check: op=1100011 -> illegal=1 in DECODE only, next state FETCH, no write enable; reset asserted in MEMWRITE -> memwrite=0 same cycle, FETCH next.
